crc_chk_seq: RTL and testbench

//   Downstream of the error-injection stage in the table-based DEC bench. Recomputes the CRC of each

---
 rtl/crc_chk_pkg.sv | 41 ++++
 rtl/crc_chk_seq_if.sv | 37 +++
 rtl/crc_chk_seq_chunk_step.sv | 37 +++
 rtl/crc_chk_seq.sv | 166 ++++++++++++++++
 tb/tb_crc_chk_seq.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_chk_pkg.sv
// Shared types, CRC-32 defaults and the bitwise CRC fold used by the frame checker.
// The fold works on maximum-width vectors so that the RTL and its models can share one routine.
package crc_chk_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} crc_chk_state_t;

  localparam int              CRC32_DATA_WIDTH  = 512;
  localparam int              CRC32_WIDTH       = 32;
  localparam int              CRC32_CHUNK_WIDTH = 64;
  localparam int              CRC32_CNT_WIDTH   = 32;
  localparam logic [31:0]     CRC32_POLY        = 32'h04C11DB7;
  localparam logic [31:0]     CRC32_INIT        = 32'h0;

  localparam int              CRC_MAX_WIDTH     = 64;
  localparam int              CHUNK_MAX_WIDTH   = 512;

  // Folds the low chunk_width bits of chunk into the low crc_width bits of crc, MSB first.
  function automatic logic [CRC_MAX_WIDTH-1:0] crc_fold(
    input logic [CRC_MAX_WIDTH-1:0]   crc,
    input logic [CHUNK_MAX_WIDTH-1:0] chunk,
    input logic [CRC_MAX_WIDTH-1:0]   poly,
    input int                         crc_width,
    input int                         chunk_width
  );
    logic [CRC_MAX_WIDTH-1:0]   c;
    logic [CRC_MAX_WIDTH-1:0]   top_mask;
    logic [CHUNK_MAX_WIDTH-1:0] bit_mask;
    logic                       fb;
    c        = crc;
    top_mask = CRC_MAX_WIDTH'(1) << (crc_width - 1);
    for (int i = CHUNK_MAX_WIDTH - 1; i >= 0; i--) begin
      if (i < chunk_width) begin
        bit_mask = CHUNK_MAX_WIDTH'(1) << i;
        fb       = (|(c & top_mask)) ^ (|(chunk & bit_mask));
        c        = (c << 1) ^ (fb ? poly : '0);
      end
    end
    return c & ((top_mask << 1) - CRC_MAX_WIDTH'(1));
  endfunction

endpackage

// File: rtl/crc_chk_seq_if.sv
// Frame input and scored-result bundle of the CRC checker.
// Names carry the checker's own direction: _i into the checker, _o out of it.
interface crc_chk_seq_if #(
  parameter int DATA_WIDTH = 512,
  parameter int CRC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 32
) ();

  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic [CRC_WIDTH-1:0]  checksum_i;
  logic                  corrupted_i;

  logic                  valid_o;
  logic                  error_o;
  logic                  corrupted_o;
  logic                  miss_o;
  logic                  false_alarm_o;
  logic [CNT_WIDTH-1:0]  frame_cnt_o;
  logic [CNT_WIDTH-1:0]  detect_cnt_o;
  logic [CNT_WIDTH-1:0]  miss_cnt_o;
  logic [CNT_WIDTH-1:0]  drop_cnt_o;

  modport master (
    output valid_i, data_i, checksum_i, corrupted_i,
    input  ready_o, valid_o, error_o, corrupted_o, miss_o, false_alarm_o,
    input  frame_cnt_o, detect_cnt_o, miss_cnt_o, drop_cnt_o
  );

  modport slave (
    input  valid_i, data_i, checksum_i, corrupted_i,
    output ready_o, valid_o, error_o, corrupted_o, miss_o, false_alarm_o,
    output frame_cnt_o, detect_cnt_o, miss_cnt_o, drop_cnt_o
  );

endinterface

// File: rtl/crc_chk_seq_chunk_step.sv
// One combinational CRC step: folds a CHUNK_WIDTH-bit chunk into the running CRC.
module crc_chunk_step
  import crc_chk_pkg::*;
#(
  parameter int                   CRC_WIDTH   = CRC32_WIDTH,
  parameter int                   CHUNK_WIDTH = CRC32_CHUNK_WIDTH,
  parameter logic [CRC_WIDTH-1:0] POLY        = CRC32_POLY
) (
  input  logic [CRC_WIDTH-1:0]   crc_i,
  input  logic [CHUNK_WIDTH-1:0] chunk_i,
  output logic [CRC_WIDTH-1:0]   crc_o
);

  logic [CRC_MAX_WIDTH-1:0]   crc_ext;
  logic [CRC_MAX_WIDTH-1:0]   poly_ext;
  logic [CHUNK_MAX_WIDTH-1:0] chunk_ext;
  logic [CRC_MAX_WIDTH-1:0]   fold;

  always_comb begin
    crc_ext                     = '0;
    crc_ext[CRC_WIDTH-1:0]      = crc_i;
    poly_ext                    = '0;
    poly_ext[CRC_WIDTH-1:0]     = POLY;
    chunk_ext                   = '0;
    chunk_ext[CHUNK_WIDTH-1:0]  = chunk_i;
    fold = crc_fold(crc_ext, chunk_ext, poly_ext, CRC_WIDTH, CHUNK_WIDTH);
  end

  assign crc_o = fold[CRC_WIDTH-1:0];

  // The fold clears everything above CRC_WIDTH, so those bits are intentionally dropped.
  if (CRC_WIDTH < CRC_MAX_WIDTH) begin : g_hi_bits
    logic unused_fold_hi;
    assign unused_fold_hi = ^fold[CRC_MAX_WIDTH-1:CRC_WIDTH];
  end

endmodule

// File: rtl/crc_chk_seq.sv
// Multi-cycle CRC checker: captures a frame, folds it CHUNK_WIDTH bits per cycle,
// scores the result against the injector's corrupted flag and keeps saturating statistics.
module crc_chk_seq
  import crc_chk_pkg::*;
#(
  parameter int                   DATA_WIDTH  = CRC32_DATA_WIDTH,
  parameter int                   CRC_WIDTH   = CRC32_WIDTH,
  parameter int                   CHUNK_WIDTH = CRC32_CHUNK_WIDTH,
  parameter                       POLY        = CRC32_POLY,
  parameter logic [CRC_WIDTH-1:0] INIT        = '0,
  parameter int                   CNT_WIDTH   = CRC32_CNT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  crc_chk_seq_if.slave bus
);

  localparam int                   NCHUNK   = DATA_WIDTH / CHUNK_WIDTH;
  localparam int                   IDX_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [CRC_WIDTH-1:0] POLY_C   = CRC_WIDTH'(POLY);

  if ((DATA_WIDTH % CHUNK_WIDTH) != 0 || CRC_WIDTH != $bits(POLY) ||
      CRC_WIDTH > CRC_MAX_WIDTH || CHUNK_WIDTH > CHUNK_MAX_WIDTH) begin : g_param_check
    $fatal(1, "crc_chk_seq: inconsistent DATA_WIDTH/CHUNK_WIDTH/CRC_WIDTH/POLY");
  end

  crc_chk_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CRC_WIDTH-1:0]    checksum_q, checksum_d;
  logic                    corrupted_q, corrupted_d;
  logic [CRC_WIDTH-1:0]    crc_q, crc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic                    valid_q, valid_d;
  logic                    error_q, error_d;
  logic                    corr_out_q, corr_out_d;
  logic                    miss_q, miss_d;
  logic                    false_alarm_q, false_alarm_d;
  logic [CNT_WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0]    detect_cnt_q, detect_cnt_d;
  logic [CNT_WIDTH-1:0]    miss_cnt_q, miss_cnt_d;
  logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;

  logic                    ready;
  logic                    crc_err;
  logic [CRC_WIDTH-1:0]    crc_step;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // data_q shifts left each CALC cycle, so the next chunk is always the top slice.
  crc_chunk_step #(
    .CRC_WIDTH   (CRC_WIDTH),
    .CHUNK_WIDTH (CHUNK_WIDTH),
    .POLY        (POLY_C)
  ) u_step (
    .crc_i   (crc_q),
    .chunk_i (data_q[DATA_WIDTH-1 -: CHUNK_WIDTH]),
    .crc_o   (crc_step)
  );

  assign ready   = (state_q == IDLE);
  assign crc_err = (crc_q != checksum_q);

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    checksum_d    = checksum_q;
    corrupted_d   = corrupted_q;
    crc_d         = crc_q;
    idx_d         = idx_q;
    valid_d       = 1'b0;
    error_d       = error_q;
    corr_out_d    = corr_out_q;
    miss_d        = miss_q;
    false_alarm_d = false_alarm_q;
    frame_cnt_d   = frame_cnt_q;
    detect_cnt_d  = detect_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    drop_cnt_d    = drop_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          data_d      = bus.data_i;
          checksum_d  = bus.checksum_i;
          corrupted_d = bus.corrupted_i;
          crc_d       = INIT;
          idx_d       = '0;
          state_d     = CALC;
        end
      end
      CALC: begin
        crc_d  = crc_step;
        data_d = data_q << CHUNK_WIDTH;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        valid_d       = 1'b1;
        error_d       = crc_err;
        corr_out_d    = corrupted_q;
        miss_d        = corrupted_q & ~crc_err;
        false_alarm_d = crc_err & ~corrupted_q;
        frame_cnt_d   = sat_inc(frame_cnt_q);
        if (crc_err)                 detect_cnt_d = sat_inc(detect_cnt_q);
        if (corrupted_q && !crc_err) miss_cnt_d   = sat_inc(miss_cnt_q);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The source cannot be stalled; a frame offered while busy is lost and counted.
    if (bus.valid_i && !ready) drop_cnt_d = sat_inc(drop_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      data_q        <= '0;
      checksum_q    <= '0;
      corrupted_q   <= 1'b0;
      crc_q         <= '0;
      idx_q         <= '0;
      valid_q       <= 1'b0;
      error_q       <= 1'b0;
      corr_out_q    <= 1'b0;
      miss_q        <= 1'b0;
      false_alarm_q <= 1'b0;
      frame_cnt_q   <= '0;
      detect_cnt_q  <= '0;
      miss_cnt_q    <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      checksum_q    <= checksum_d;
      corrupted_q   <= corrupted_d;
      crc_q         <= crc_d;
      idx_q         <= idx_d;
      valid_q       <= valid_d;
      error_q       <= error_d;
      corr_out_q    <= corr_out_d;
      miss_q        <= miss_d;
      false_alarm_q <= false_alarm_d;
      frame_cnt_q   <= frame_cnt_d;
      detect_cnt_q  <= detect_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign bus.ready_o       = ready;
  assign bus.valid_o       = valid_q;
  assign bus.error_o       = error_q;
  assign bus.corrupted_o   = corr_out_q;
  assign bus.miss_o        = miss_q;
  assign bus.false_alarm_o = false_alarm_q;
  assign bus.frame_cnt_o   = frame_cnt_q;
  assign bus.detect_cnt_o  = detect_cnt_q;
  assign bus.miss_cnt_o    = miss_cnt_q;
  assign bus.drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_crc_chk_seq.sv
// Scoreboard bench for crc_chk_seq: directed cases, a 4-bit-counter saturation instance,
// and randomized injector traffic checked against a polynomial-division CRC model.
module tb_crc_chk_seq;
  import crc_chk_pkg::*;

  localparam int DW     = 512;
  localparam int CW     = 32;
  localparam int NCHUNK = 8;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst4_n = 1'b0;
  always #5 clk = ~clk;

  crc_chk_seq_if #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .CNT_WIDTH(32)) bus  ();
  crc_chk_seq_if #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .CNT_WIDTH(4))  bus4 ();

  crc_chk_seq #(
    .DATA_WIDTH(DW), .CRC_WIDTH(CW), .CHUNK_WIDTH(64),
    .POLY(32'h04C11DB7), .INIT(32'h0), .CNT_WIDTH(32)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  crc_chk_seq #(
    .DATA_WIDTH(DW), .CRC_WIDTH(CW), .CHUNK_WIDTH(64),
    .POLY(32'h04C11DB7), .INIT(32'h0), .CNT_WIDTH(4)
  ) dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));

  typedef struct {
    int   cyc;
    logic err;
    logic corr;
    logic miss;
    logic fa;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   next_free = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_frame = 0, exp_detect = 0, exp_miss = 0, exp_drop = 0;
  int   frames_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Remainder of M(x)*x^32 divided by G(x): the CRC with zero seed and no reflection.
  function automatic logic [CW-1:0] ref_crc(input logic [DW-1:0] d);
    logic [DW+CW-1:0] m;
    logic [CW:0]      g;
    m = {d, {CW{1'b0}}};
    g = {1'b1, CRC32_POLY};
    for (int i = DW + CW - 1; i >= CW; i--)
      if (m[i]) m[i -: CW+1] = m[i -: CW+1] ^ g;
    return m[CW-1:0];
  endfunction

  // Checksum generator on the injector side, built from the shared fold routine.
  function automatic logic [CW-1:0] gen_crc(input logic [DW-1:0] d);
    logic [CRC_MAX_WIDTH-1:0]   c;
    logic [CRC_MAX_WIDTH-1:0]   p;
    logic [CHUNK_MAX_WIDTH-1:0] ch;
    c = '0;
    p = '0;
    p[CW-1:0] = CRC32_POLY;
    for (int k = 0; k < NCHUNK; k++) begin
      ch = '0;
      ch[63:0] = d[DW-1-64*k -: 64];
      c = crc_fold(c, ch, p, CW, 64);
    end
    return c[CW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[32*k +: 32] = $urandom();
    return d;
  endfunction

  // One input cycle, called at a negedge; models acceptance and drops for the coming edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c, input logic corr);
    int   edge_n;
    logic exp_ready;
    logic err;
    exp_t e;
    edge_n    = cyc + 1;
    exp_ready = (edge_n >= next_free);
    chk("ready_o", bus.ready_o, exp_ready);
    chk("drop_cnt_o", bus.drop_cnt_o, exp_drop);
    bus.valid_i     = v;
    bus.data_i      = d;
    bus.checksum_i  = c;
    bus.corrupted_i = corr;
    if (v) begin
      if (exp_ready) begin
        err    = (ref_crc(d) != c);
        e.cyc  = edge_n + NCHUNK + 1;
        e.err  = err;
        e.corr = corr;
        e.miss = corr & ~err;
        e.fa   = err & ~corr;
        sb.push_back(e);
        next_free = edge_n + NCHUNK + 2;
      end else begin
        exp_drop++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    bus.valid_i = 1'b0;
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    exp_frame  = 0;
    exp_detect = 0;
    exp_miss   = 0;
    exp_drop   = 0;
    next_free  = cyc + 1;
    chk("reset_valid_o", bus.valid_o, 0);
    chk("reset_frame_cnt", bus.frame_cnt_o, 0);
    chk("reset_detect_cnt", bus.detect_cnt_o, 0);
    chk("reset_miss_cnt", bus.miss_cnt_o, 0);
    chk("reset_drop_cnt", bus.drop_cnt_o, 0);
  endtask

  // Monitor: pops the expected result whenever the checker presents one.
  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: valid_o=1 at cycle %0d, expected no result", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        frames_seen++;
        exp_frame++;
        if (e.err)  exp_detect++;
        if (e.miss) exp_miss++;
        chk("latency", cyc, e.cyc);
        chk("error_o", bus.error_o, e.err);
        chk("corrupted_o", bus.corrupted_o, e.corr);
        chk("miss_o", bus.miss_o, e.miss);
        chk("false_alarm_o", bus.false_alarm_o, e.fa);
        chk("frame_cnt_o", bus.frame_cnt_o, exp_frame);
        chk("detect_cnt_o", bus.detect_cnt_o, exp_detect);
        chk("miss_cnt_o", bus.miss_cnt_o, exp_miss);
        $display("frame %0d: cycle=%0d error=%0b corrupted=%0b miss=%0b false_alarm=%0b",
                 frames_seen, cyc, bus.error_o, bus.corrupted_o, bus.miss_o, bus.false_alarm_o);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          corr;
    int            drop_before, frame_before, flips, pos;

    bus.valid_i  = 1'b0; bus.data_i  = '0; bus.checksum_i  = '0; bus.corrupted_i  = 1'b0;
    bus4.valid_i = 1'b0; bus4.data_i = '0; bus4.checksum_i = '0; bus4.corrupted_i = 1'b0;
    do_reset(3);
    rst4_n = 1'b1;

    // All-zero frame with zero checksum
    cycle(1'b1, '0, '0, 1'b0);
    idle(12);

    // Data 1: golden checksum, then checksum bit 0 flipped and flagged corrupted
    d = '0;
    d[0] = 1'b1;
    c = gen_crc(d);
    cycle(1'b1, d, c, 1'b0);
    idle(12);
    cycle(1'b1, d, c ^ 32'h1, 1'b1);
    idle(12);

    // Flagged corrupted but payload intact: a miss
    d = rand_data();
    cycle(1'b1, d, gen_crc(d), 1'b1);
    idle(12);

    // valid_i held for 20 cycles
    drop_before  = bus.drop_cnt_o;
    frame_before = bus.frame_cnt_o;
    for (int i = 0; i < 20; i++) begin
      d = rand_data();
      cycle(1'b1, d, gen_crc(d), 1'b0);
    end
    idle(12);
    chk("burst_drops", bus.drop_cnt_o - drop_before, 18);
    chk("burst_frames", bus.frame_cnt_o - frame_before, 2);

    // Reset while the frame is on chunk 3
    d = rand_data();
    cycle(1'b1, d, gen_crc(d), 1'b0);
    idle(3);
    do_reset(1);
    idle(12);
    d = rand_data();
    cycle(1'b1, d, gen_crc(d) ^ 32'h8000_0000, 1'b1);
    idle(12);

    // Saturation on the 4-bit-counter instance
    for (int n = 1; n <= 17; n++) begin
      d = rand_data();
      bus4.valid_i     = 1'b1;
      bus4.data_i      = d;
      bus4.checksum_i  = ref_crc(d) ^ 32'h1;
      bus4.corrupted_i = 1'b1;
      @(negedge clk);
      bus4.valid_i = 1'b0;
      repeat (11) @(negedge clk);
      chk("sat_frame_cnt", bus4.frame_cnt_o, (n > 15) ? 15 : n);
      chk("sat_detect_cnt", bus4.detect_cnt_o, (n > 15) ? 15 : n);
    end
    chk("sat_miss_cnt", bus4.miss_cnt_o, 0);

    // Randomized injector traffic, including frames offered while busy
    for (int f = 0; f < 1500; f++) begin
      d = rand_data();
      c = gen_crc(d);
      flips = $urandom_range(0, 2);
      for (int k = 0; k < flips; k++) begin
        pos = $urandom_range(0, DW + CW - 1);
        if (pos < DW) d[pos] = ~d[pos];
        else          c[pos-DW] = ~c[pos-DW];
      end
      corr = (flips > 0);
      cycle(1'b1, d, c, corr);
      idle($urandom_range(0, 12));
    end
    idle(14);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
